// File: rtl/fp_classify_vec.sv
// fp_classify_vec: multi-lane pipelined FP classifier (FCLASS masks) behind a valid/ready skid buffer
//
// Parameters:
//   FP_FORMAT  0 = FP32 (default), 1 = FP64, 2 = FP16, 3 = BF16
//   LANES      operands per beat (>= 1)
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o     input beat handshake; ready_o comes straight from a flop
//   a_i                   packed operands, lane k = a_i[k*FP_WIDTH +: FP_WIDTH]
//   lane_en_i             per-lane enable, sampled with the data; disabled lanes give 10'h000
//   valid_o / ready_i     output beat handshake
//   class_o               packed 10-bit class masks, lane k = class_o[k*10 +: 10]
//   any_nan_o             some enabled lane of the output beat is a NaN
//   sticky_clr_i          clears the sticky summary
//   sticky_o              OR of every accepted beat's masks since the last clear
// Build option: define FP_CLASSIFY_STICKY_EN to get the sticky summary; otherwise
// sticky_o is tied to zero and sticky_clr_i is ignored.
module fp_classify_vec #(
    parameter int FP_FORMAT = 0,
    parameter int LANES = 2,
    localparam int EXP_W = FP_FORMAT == 1 ? 11 : FP_FORMAT == 2 ? 5 : 8,
    localparam int MAN_W = FP_FORMAT == 1 ? 52 : FP_FORMAT == 2 ? 10 : FP_FORMAT == 3 ? 7 : 23,
    localparam int FP_WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [LANES*FP_WIDTH-1:0] a_i,
    input  logic [LANES-1:0]          lane_en_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LANES*10-1:0]       class_o,
    output logic                      any_nan_o,
    input  logic                      sticky_clr_i,
    output logic [9:0]                sticky_o
);
    typedef struct packed {
        logic sign;
        logic is_zero;
        logic is_sub;
        logic is_norm;
        logic is_inf;
        logic is_snan;
        logic is_qnan;
    } fp_info_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic fp_info_t fp_info(input logic [FP_WIDTH-1:0] v);
        fp_info_t fi;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = v[FP_WIDTH-2 -: EXP_W];
        m = v[MAN_W-1:0];
        fi.sign = v[FP_WIDTH-1];
        fi.is_zero = ~|e & ~|m;
        fi.is_sub = ~|e & |m;
        fi.is_norm = ~&e & |e;
        fi.is_inf = &e & ~|m;
        fi.is_snan = &e & |m & ~m[MAN_W-1];
        fi.is_qnan = &e & m[MAN_W-1];
        return fi;
    endfunction

    function automatic logic [9:0] classify(input logic [FP_WIDTH-1:0] v, input logic en);
        fp_info_t fi;
        fi = fp_info(v);
        return en ? {fi.is_qnan, fi.is_snan,
                     ~fi.sign & fi.is_inf, ~fi.sign & fi.is_norm, ~fi.sign & fi.is_sub, ~fi.sign & fi.is_zero,
                     fi.sign & fi.is_zero, fi.sign & fi.is_sub, fi.sign & fi.is_norm, fi.sign & fi.is_inf} : 10'h000;
    endfunction

    state_t state_q, state_d;
    logic [LANES*10-1:0] beat_class, out_q, skid_q;
    logic [9:0] beat_or;
    logic accept, load_out, out_from_skid, load_skid;
    logic valid_q, ready_q;

    assign accept = valid_i & ready_q;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign class_o = out_q;

    always_comb begin
        beat_class = '0;
        beat_or = '0;
        any_nan_o = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            beat_class[k*10 +: 10] = classify(a_i[k*FP_WIDTH +: FP_WIDTH], lane_en_i[k]);
            beat_or = beat_or | beat_class[k*10 +: 10];
            any_nan_o = any_nan_o | (|out_q[k*10+8 +: 2]);
        end
    end

    always_comb begin
        state_d = state_q;
        load_out = 1'b0;
        out_from_skid = 1'b0;
        load_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                state_d = accept ? ONE : EMPTY;
                load_out = accept;
            end
            ONE: begin
                state_d = accept ? (ready_i ? ONE : FULL) : (ready_i ? EMPTY : ONE);
                load_out = accept & ready_i;
                load_skid = accept & ~ready_i;
            end
            FULL: begin
                state_d = ready_i ? ONE : FULL;
                load_out = ready_i;
                out_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // valid/ready are registered copies of the next-state decode so both leave the block as flop outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q <= '0;
            skid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= state_d != EMPTY;
            ready_q <= state_d != FULL;
            if (load_out) out_q <= out_from_skid ? skid_q : beat_class;
            if (load_skid) skid_q <= beat_class;
        end
    end

`ifdef FP_CLASSIFY_STICKY_EN
    logic [9:0] sticky_q;
    assign sticky_o = sticky_q;
    // a clear on an accept cycle drops the old summary but keeps the new beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sticky_q <= '0;
        else if (accept) sticky_q <= (sticky_clr_i ? 10'h000 : sticky_q) | beat_or;
        else if (sticky_clr_i) sticky_q <= '0;
    end
`else
    logic [10:0] unused_sticky;
    assign unused_sticky = {sticky_clr_i, beat_or};
    assign sticky_o = 10'h000;
`endif
endmodule
